// File: rtl/dac_cfg_serializer.sv
// Serializer for the DAC configuration chains: clears both receivers, then streams
// marker-framed vref and data words MSB first on two lines that share one bit index.
module dac_cfg_serializer #(
    parameter int unsigned VREF_W     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [VREF_W-1:0] vref_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              sdo_vref,
    output logic              sdo_data,
    output logic              rx_rst_n,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SR_W    = DATA_W + 1;
    localparam int unsigned CNT_MAX = (CLR_CYCLES > SR_W) ? CLR_CYCLES : SR_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    // Frames are pre-formatted as {marker, payload, zero pad}, MSB leaves first
    logic [SR_W-1:0] r_data_sr;
    logic [SR_W-1:0] w_data_sr_nxt;
    logic [SR_W-1:0] r_vref_sr;
    logic [SR_W-1:0] w_vref_sr_nxt;
    logic            w_sdo_vref_nxt;
    logic            w_sdo_data_nxt;
    logic            w_rx_rst_n_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_data_sr <= '0;
            r_vref_sr <= '0;
            sdo_vref  <= 1'b0;
            sdo_data  <= 1'b0;
            rx_rst_n  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_data_sr <= w_data_sr_nxt;
            r_vref_sr <= w_vref_sr_nxt;
            sdo_vref  <= w_sdo_vref_nxt;
            sdo_data  <= w_sdo_data_nxt;
            rx_rst_n  <= w_rx_rst_n_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
        end
    end

    // Next state and next-cycle output values; outputs are registered from these
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_data_sr_nxt  = r_data_sr;
        w_vref_sr_nxt  = r_vref_sr;
        w_sdo_vref_nxt = 1'b0;
        w_sdo_data_nxt = 1'b0;
        w_rx_rst_n_nxt = 1'b1;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nxt    = S_CLEAR;
                    w_cnt_nxt      = '0;
                    w_data_sr_nxt  = {1'b1, data_in};
                    w_vref_sr_nxt  = SR_W'({1'b1, vref_in}) << (DATA_W - VREF_W);
                    w_rx_rst_n_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_CLEAR: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == CLR_LAST) begin
                    w_state_nxt    = S_SHIFT;
                    w_cnt_nxt      = '0;
                    w_sdo_data_nxt = r_data_sr[SR_W-1];
                    w_sdo_vref_nxt = r_vref_sr[SR_W-1];
                    w_data_sr_nxt  = r_data_sr << 1;
                    w_vref_sr_nxt  = r_vref_sr << 1;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    w_rx_rst_n_nxt = 1'b0;
                end
            end
            S_SHIFT: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == K_LAST) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt      = r_cnt + CNT_W'(1);
                    w_sdo_data_nxt = r_data_sr[SR_W-1];
                    w_sdo_vref_nxt = r_vref_sr[SR_W-1];
                    w_data_sr_nxt  = r_data_sr << 1;
                    w_vref_sr_nxt  = r_vref_sr << 1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_cfg_serializer.sv
// Scoreboard bench for dac_cfg_serializer: an acceptance model queues expected codes,
// a negedge monitor reassembles each frame through marker-stop receiver models.
module tb_dac_cfg_serializer;

    localparam int unsigned VREF_W     = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CLR_CYCLES = 2;
    localparam int unsigned BUSY_LEN   = CLR_CYCLES + (DATA_W + 1) + 1;
    localparam int unsigned FRAME_GAP  = BUSY_LEN + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic [VREF_W-1:0] vref_in;
    logic [DATA_W-1:0] data_in;
    logic              sdo_vref;
    logic              sdo_data;
    logic              rx_rst_n;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int free_at  = 0;
    int frames   = 0;

    logic [VREF_W+DATA_W-1:0] exp_q[$];

    dac_cfg_serializer #(
        .VREF_W    (VREF_W),
        .DATA_W    (DATA_W),
        .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .vref_in (vref_in),
        .data_in (data_in),
        .sdo_vref(sdo_vref),
        .sdo_data(sdo_data),
        .rx_rst_n(rx_rst_n),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: the model accepts a load only when the block is idle again
    task automatic tick();
        @(posedge clk);
        if (!rst && load && cyc >= free_at) begin
            exp_q.push_back({vref_in, data_in});
            free_at = cyc + FRAME_GAP;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [VREF_W-1:0] v, input logic [DATA_W-1:0] d, input int wait_cycles);
        vref_in = v;
        data_in = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        repeat (wait_cycles) tick();
    endtask

    // Monitor with receiver models of both marker-stop chains
    logic [DATA_W:0] rx_d;
    logic [VREF_W:0] rx_v;
    logic [DATA_W:0] ds;
    logic [DATA_W:0] vs;
    int busy_cnt, clr_cnt, sh_cnt;
    logic [VREF_W+DATA_W-1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            rx_d = '0; rx_v = '0; ds = '0; vs = '0;
            busy_cnt = 0; clr_cnt = 0; sh_cnt = 0;
        end else begin
            if (done) begin
                frames++;
                chk("busy_cycles", 32'(busy_cnt + 1), 32'(BUSY_LEN));
                chk("clear_cycles", 32'(clr_cnt), 32'(CLR_CYCLES));
                chk("shift_cycles", 32'(sh_cnt), 32'(DATA_W + 1));
                if (exp_q.size() == 0) begin
                    chk("frame_expected", 32'(0), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("data_stream", 32'(ds), 32'({1'b1, e[DATA_W-1:0]}));
                    chk("vref_stream", 32'(vs), 32'({1'b1, e[VREF_W+DATA_W-1:DATA_W], {(DATA_W-VREF_W){1'b0}}}));
                    chk("data_rx_word", 32'(rx_d), 32'({1'b1, e[DATA_W-1:0]}));
                    chk("vref_rx_word", 32'(rx_v), 32'({1'b1, e[VREF_W+DATA_W-1:DATA_W]}));
                end
                busy_cnt = 0; clr_cnt = 0; sh_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
                if (!rx_rst_n) begin
                    clr_cnt++;
                end else begin
                    ds = {ds[DATA_W-1:0], sdo_data};
                    vs = {vs[DATA_W-1:0], sdo_vref};
                    sh_cnt++;
                end
            end else begin
                busy_cnt = 0; clr_cnt = 0; sh_cnt = 0;
            end
            if (!rx_rst_n) begin
                rx_d = '0;
                rx_v = '0;
            end else begin
                if (!rx_d[DATA_W]) rx_d = {rx_d[DATA_W-1:0], sdo_data};
                if (!rx_v[VREF_W]) rx_v = {rx_v[VREF_W-1:0], sdo_vref};
            end
        end
    end

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        vref_in = '0;
        data_in = '0;
        #3;
        chk("reset_outputs", 32'({sdo_vref, sdo_data, rx_rst_n, busy, done}), 32'h0);
        tick();
        tick();
        chk("reset_outputs_held", 32'({sdo_vref, sdo_data, rx_rst_n, busy, done}), 32'h0);
        rst = 1'b0;

        // Idle after reset: only the receiver clear is released
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 4)
                chk("idle_outputs", 32'({sdo_vref, sdo_data, rx_rst_n, busy, done}), 32'b00100);
        end

        // Basic frame
        send(4'hA, 8'hC5, 15);

        // Inputs change after capture; extra loads mid-frame and in the DONE cycle
        vref_in = 4'hA; data_in = 8'hC5; load = 1'b1;
        tick();
        load = 1'b0; vref_in = '0; data_in = '0;
        repeat (4) tick();
        load = 1'b1; tick(); load = 1'b0;
        repeat (6) tick();
        load = 1'b1; tick(); load = 1'b0;
        repeat (15) tick();

        // Load held high: back-to-back frames
        vref_in = 4'h3; data_in = 8'hFF; load = 1'b1;
        tick();
        data_in = 8'h00;
        repeat (29) tick();
        load = 1'b0;
        repeat (15) tick();

        // Reset while shift bit k=4 is on the lines
        vref_in = 4'h9; data_in = 8'h96; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (CLR_CYCLES + 4) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({sdo_vref, sdo_data, rx_rst_n, busy, done}), 32'h0);
        exp_q.delete();
        free_at = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        send(4'h5, 8'h3C, 15);

        // Edge codes
        send(4'h0, 8'h00, 15);
        send(4'hF, 8'hFF, 15);

        // Random loads, codes and spacing
        for (int i = 0; i < 400; i++) begin
            vref_in = VREF_W'($urandom);
            data_in = DATA_W'($urandom);
            load    = ($urandom_range(0, 3) == 0);
            tick();
        end
        load = 1'b0;
        repeat (20) tick();

        chk("frames_pending", 32'(exp_q.size()), 32'h0);
        chk("frames_seen_min", 32'(frames >= 12), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
